// File: rtl/uart_rx_checker.sv
// uart_rx_checker
//   Loopback 8N1 UART receiver for the pattern-ROM serial output. Decodes
//   frames on a looped-back pin, strobes each good byte or framing error,
//   and keeps saturating good/error frame counters for on-board self-check.
//
// Parameters
//   BAUD_DIV  clock cycles per bit (25 MHz / 9600 = 2604), legal 4..65535
//   CNT_W     width of the saturating frame counters
//
// Ports
//   clk         system clock (25 MHz PLL output)
//   resetn      asynchronous active-low reset
//   rx_in       serial line, asynchronous to clk, idle high
//   data_out    last correctly framed byte, holds between frames
//   data_valid  one-cycle strobe, data_out updated this cycle
//   frame_err   one-cycle strobe, stop bit sampled low
//   busy        high whenever the receiver is not idle
//   rx_count    good frames received, saturating at all-ones
//   err_count   framing errors, saturating at all-ones
module uart_rx_checker #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_in,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  // The timer expires when it reads zero, so it is loaded with N-1 to
  // place the sample exactly N cycles after the load edge.
  localparam logic [15:0] LP_HALF_M1 = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] LP_BAUD_M1 = 16'(BAUD_DIV - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_state;
  logic [15:0]      r_timer;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_rx_s;
  logic             w_expire;

  assign w_rx_s   = r_sync2;
  assign w_expire = (r_timer == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Synchronizer resets to the idle level so reset release is not a start edge.
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_rx_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (!w_expire) begin
        r_timer <= r_timer - 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_timer <= LP_HALF_M1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_expire) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_timer   <= LP_BAUD_M1;
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_expire) begin
            r_shift <= {w_rx_s, r_shift[7:1]};
            r_timer <= LP_BAUD_M1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (w_expire) begin
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              if (r_rx_cnt != '1) begin
                r_rx_cnt <= r_rx_cnt + CNT_W'(1);
              end
              r_state <= S_IDLE;
            end else begin
              r_ferr <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
              end
              r_state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != S_IDLE);
  assign rx_count   = r_rx_cnt;
  assign err_count  = r_err_cnt;

endmodule

// File: doc/uart_rx_checker.md
# uart_rx_checker

Loopback receiver for the pattern-ROM serial output. It samples one looped-back output pin in the 25 MHz PLL clock domain and decodes 8N1 UART frames at 9600 baud. Each frame yields a received byte with a valid strobe, or a framing-error strobe. Saturating good-frame and error counters let the pattern stream be self-checked on the board, for example with the LEDs or a logic analyzer.

## Interface

- BAUD_DIV, 2604, clock cycles per bit (25 MHz / 9600); legal range 4..65535
- CNT_W, 16, width of the saturating frame counters
- clk  in  1  system clock (25 MHz PLL output)
- resetn  in  1  reset; one clock, reset is asynchronous and active-low
- rx_in  in  1  serial line, asynchronous to clk, idle high
- data_out  out  8  last correctly framed byte; holds between frames
- data_valid  out  1  one-cycle strobe, data_out updated this cycle
- frame_err  out  1  one-cycle strobe, stop bit sampled low
- busy  out  1  high whenever the FSM is not in IDLE
- rx_count  out  CNT_W  good frames received, saturating at all-ones
- err_count  out  CNT_W  framing errors, saturating at all-ones

## Operation

- Input synchronizer: rx_in passes through 2 flops, giving rx_s.
  - Both flops reset to 1 (idle line), so reset never looks like a start edge.
- Bit-timer: 16-bit down-counter. HALF = BAUD_DIV/2, integer floor.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On rx_s == 0, load timer for HALF cycles and go to START.
  - t0 is the first cycle in which rx_s is low.
- START: at timer expiry (t0+HALF), sample rx_s.
  - If rx_s == 1, treat it as a glitch and return to IDLE. No strobe, no count.
  - If rx_s == 0, reload BAUD_DIV, clear the bit index and go to DATA.
- DATA: at each expiry, sample rx_s into the shift register, LSB first.
  - Bit k (0..7) is sampled at t0+HALF+(k+1)*BAUD_DIV.
  - After bit 7, reload BAUD_DIV and go to STOP.
- STOP: sample at t0+HALF+9*BAUD_DIV.
  - rx_s == 1:
    - data_out <= shift register, data_valid pulse, rx_count++ (saturating).
    - Go to IDLE.
  - rx_s == 0:
    - frame_err pulse, err_count++ (saturating), data_out unchanged.
    - Go to BREAK.
- BREAK: wait for rx_s == 1, then go to IDLE. Covers a line held low (break condition).
- Back-to-back frames:
  - After a valid stop, the FSM is in IDLE by t0+HALF+9*BAUD_DIV+1.
  - A start edge arriving half a bit after the stop-bit centre is accepted.
- data_valid and frame_err are never high in the same cycle.
- Counters hold at 2^CNT_W-1 once reached and never wrap.

## Timing

- Reset, asynchronous, effective immediately and mid-frame included:
  - data_out=0x00, data_valid=0, frame_err=0, busy=0, rx_count=0, err_count=0.
  - FSM returns to IDLE and the partial frame is discarded.
- Latency from an rx_in edge to its rx_s effect: 2 clk cycles.
- Strobe timing:
  - data_valid or frame_err is high for exactly the one cycle after the clock edge that samples the stop bit.
  - The counters update on that same edge.
- busy rises in cycle t0+1 and falls in the cycle after the stop sample.
  - For BREAK, busy falls in the cycle after rx_s returns high.
- All outputs are registered. There are no combinational paths from rx_in.

## Test plan

- Default-params smoke test:
  - Hold resetn low, then check all outputs are 0.
  - Release, then send 0x55 at 2604 clk/bit.
  - Expect data_out=0x55 with one data_valid pulse at t0+1302+9*2604+1, rx_count=1, busy low afterwards.
- Back-to-back stream (BAUD_DIV=16):
  - Send 0x00, 0xFF, 0xA5 with one stop bit each.
  - Expect three data_valid pulses exactly 160 cycles apart, data_out sequence 0x00/0xFF/0xA5, rx_count=3, err_count=0.
- Framing error (BAUD_DIV=16):
  - Send 0x3C with stop bit 0, hold the line low 48 more cycles, then high, then send 0x81.
  - Expect one frame_err pulse, err_count=1, data_out still 0x00 and busy high throughout the break.
  - Then expect 0x81 valid and rx_count=1.
- Start glitch (BAUD_DIV=16): drive rx_in low for 4 cycles, then high.
  - Expect busy high for about 8 cycles, then no strobes and both counters unchanged.
  - A following 0x12 is received correctly.
- Reset mid-frame (BAUD_DIV=16): assert resetn during data bit 4 of 0xC3.
  - Expect outputs to clear asynchronously.
  - Release with the line idle, send 0x7E, and expect data_out=0x7E and rx_count=1.
- Saturation (BAUD_DIV=16, CNT_W=2):
  - Send 5 good frames and 5 bad frames.
  - Expect rx_count and err_count to stick at 3 with no wrap, while strobes still fire for every frame.
